// File: rtl/ldl_fifo_warb_v1.sv
// ldl_fifo_warb_v1: burst arbiter feeding one FIFO write port; round-robin, fixed priority with LDL_FIFO_WARB_PRIO_EN.
// Latency: grant one cycle after request, then one combinational transfer per cycle; one idle bubble between bursts.
// Backpressure: full stalls the owner's transfer and holds counter/owner/state; non-owners wait for the next grant.
module ldl_fifo_warb_v1 #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int MAXB = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    last,
    input  logic [N*DW-1:0] din,
    input  logic            full,
    output logic [N-1:0]    ack,
    output logic            we,
    output logic [DW-1:0]   dout,
    output logic [N-1:0]    gnt,
    output logic            busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAXB + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] own;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] own_nxt;
    logic          burst_end;
    logic [DW-1:0] din_a [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_a[i] = din[i*DW +: DW];
        end
    end

`ifdef LDL_FIFO_WARB_PRIO_EN
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = PW'(i);
            end
        end
    end
`else
    logic [N-1:0]  req_rot;
    logic [PW-1:0] win_off;
    logic [PW:0]   win_sum;

    // Rotate so bit 0 is the requester at ptr; first set bit is the offset from ptr.
    assign req_rot = N'({req, req} >> ptr);

    always_comb begin
        win_vld = 1'b0;
        win_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_vld = 1'b1;
                win_off = PW'(i);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        win_idx = (win_sum >= (PW+1)'(N)) ? PW'(win_sum - (PW+1)'(N)) : win_sum[PW-1:0];
    end
`endif

    assign busy    = (state == BURST);
    assign we      = busy & req[own] & ~full;
    assign ack     = we ? gnt : '0;
    assign dout    = busy ? din_a[own] : din_a[0];
    assign cnt_inc = cnt + CW'(1);
    assign own_nxt = (own == PW'(N - 1)) ? '0 : own + PW'(1);

    // A dropped request ends the burst even while full stalls it.
    assign burst_end = ~req[own] | (we & (last[own] | (cnt_inc == CW'(MAXB))));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            own   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state <= BURST;
                        gnt   <= N'(1) << win_idx;
                        own   <= win_idx;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (burst_end) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= own_nxt;
                        cnt   <= '0;
                    end else if (we) begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldl_fifo_warb_v1.sv
// Bench for ldl_fifo_warb_v1 (default round-robin build): directed scenarios plus randomized traffic against a reference model.
module tb_ldl_fifo_warb_v1;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 16;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N*DW-1:0] din;
    logic          full;
    logic [N-1:0]  ack;
    logic          we;
    logic [DW-1:0] dout;
    logic [N-1:0]  gnt;
    logic          busy;

    int total;
    int bad;

    // Reference model state: owner index (-1 when idle), search start, beats in burst.
    int m_own;
    int m_ptr;
    int m_beats;

    int ack_cnt;
    int we_owner_q[$];

    ldl_fifo_warb_v1 #(.N(N), .DW(DW), .MAXB(MAXB)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .last (last),
        .din  (din),
        .full (full),
        .ack  (ack),
        .we   (we),
        .dout (dout),
        .gnt  (gnt),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; checks outputs at the following negedge, then advances the model over the posedge.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic f, input logic [N*DW-1:0] d);
        logic       e_busy;
        logic       e_we;
        logic [N-1:0] e_ack;
        logic [N-1:0] e_gnt;
        logic [DW-1:0] e_dout;
        req = r; last = l; full = f; din = d;
        @(negedge clk);
        e_busy = (m_own >= 0);
        e_we   = e_busy && req[m_own] && !full;
        e_gnt  = e_busy ? (N'(1) << m_own) : '0;
        e_ack  = e_we ? e_gnt : '0;
        e_dout = din[(e_busy ? m_own : 0)*DW +: DW];
        chk("busy", 32'(busy), 32'(e_busy));
        chk("we",   32'(we),   32'(e_we));
        chk("ack",  32'(ack),  32'(e_ack));
        chk("gnt",  32'(gnt),  32'(e_gnt));
        chk("dout", 32'(dout), 32'(e_dout));
        if (ack[2]) ack_cnt++;
        if (e_we) we_owner_q.push_back(m_own);
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_own < 0 && req[(m_ptr + k) % N]) begin
                    m_own   = (m_ptr + k) % N;
                    m_beats = 0;
                end
            end
        end else begin
            if (!req[m_own] || (e_we && (last[m_own] || m_beats + 1 == MAXB))) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else if (e_we) begin
                m_beats++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_own = -1; m_ptr = 0; m_beats = 0;
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_we",   32'(we),   32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'(din[DW-1:0]));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N*DW-1:0] d;
        total = 0; bad = 0;
        ack_cnt = 0;
        req = '0; last = '0; full = 1'b0; din = 32'h44332211; rst = 1'b1;
        m_own = -1; m_ptr = 0; m_beats = 0;
        @(posedge clk);
        #1;
        do_reset();

        // All request, last on every beat: one-beat bursts rotating 0,1,2,3,0.
        we_owner_q.delete();
        for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 1'b0, $urandom());
        chk("rr_len", 32'(we_owner_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < we_owner_q.size()) chk("rr_seq", 32'(we_owner_q[i]), 32'(i % N));
        end

        // Single requester without last: capped at MAXB beats, bubble, then re-granted.
        do_reset();
        ack_cnt = 0;
        for (int i = 0; i < MAXB + 2; i++) cycle(4'b0100, 4'b0000, 1'b0, $urandom());
        chk("maxb_acks", 32'(ack_cnt), 32'(MAXB));
        chk("maxb_regnt", 32'(gnt), 32'h4);

        // Owner 1 stalled by full for three cycles mid-burst.
        do_reset();
        we_owner_q.delete();
        cycle(4'b0010, 4'b0000, 1'b0, 32'h00000100);
        for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, 1'b0, $urandom());
        for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, 1'b1, 32'h0000AB00);
        cycle(4'b0010, 4'b0000, 1'b0, 32'h0000AB00);
        chk("stall_beats", 32'(we_owner_q.size()), 32'd4);
        chk("stall_busy", 32'(busy), 32'd1);

        // Reset during owner 3's burst, then search restarts at index 0.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(4'b1000, 4'b0000, 1'b0, $urandom());
        chk("abort_pre_gnt", 32'(gnt), 32'h8);
        do_reset();
        cycle(4'b1010, 4'b0000, 1'b0, $urandom());
        chk("abort_regnt", 32'(gnt), 32'h2);

        // Owner 0 drops request after two beats; ptr moves to 1.
        do_reset();
        cycle(4'b0001, 4'b0000, 1'b0, $urandom());
        cycle(4'b0001, 4'b0000, 1'b0, $urandom());
        cycle(4'b0001, 4'b0000, 1'b0, $urandom());
        cycle(4'b0000, 4'b0000, 1'b0, $urandom());
        chk("drop_idle", 32'(busy), 32'd0);
        cycle(4'b0011, 4'b0000, 1'b0, $urandom());
        chk("drop_ptr", 32'(gnt), 32'h2);

        // Randomized traffic with occasional mid-run reset.
        do_reset();
        r = 4'b0101;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
            d = $urandom();
            cycle(r, 4'(($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 0),
                  ($urandom_range(0, 3) == 0), d);
            if (i == 1500) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldl_fifo_warb_v1.md
LDL_FIFO_WARB_V1 -- requirements
Module: LDL_fifo_warb_v1

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter DW, default 8, meaning data width per requester and FIFO write width.
REQ-003 SHALL have parameter MAXB, default 16, meaning maximum beats per burst (1..255).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N  per-requester write request.
REQ-007 SHALL have port last  input  N  per-requester end-of-burst marker, qualified by its ack.
REQ-008 SHALL have port din  input  N*DW  requester i data at bits [i*DW +: DW].
REQ-009 SHALL have port full  input  1  FIFO write-side full flag.
REQ-010 SHALL have port ack  output  N  one-hot transfer acknowledge to the owning requester.
REQ-011 SHALL have port we  output  1  FIFO write enable.
REQ-012 SHALL have port dout  output  DW  FIFO write data.
REQ-013 SHALL have port gnt  output  N  registered one-hot current owner, all-zero when idle.
REQ-014 SHALL have port busy  output  1  high while in state BURST.

Function
REQ-015 SHALL implement states IDLE and BURST, held in a registered FSM.
REQ-016 IDLE: when any req bit is high, SHALL select a winner, register it in gnt, clear the beat counter, and enter BURST next cycle; no transfer occurs in IDLE.
REQ-017 Winner selection SHALL be round-robin: search from index ptr upward, wrapping N-1 -> 0; first set req bit wins.
REQ-018 BURST: we = req[owner] & ~full; ack[owner] = we; all other ack bits 0; dout = din[owner] (combinational).
REQ-019 Each transfer (we=1) SHALL increment the beat counter, width $clog2(MAXB+1).
REQ-020 Burst SHALL end on the transfer with last[owner]=1, or on the transfer that makes the count equal MAXB, or in any cycle with req[owner]=0.
REQ-021 On burst end SHALL set ptr = owner+1 mod N, clear gnt, and return to IDLE; one bubble cycle between bursts.
REQ-022 full=1 in BURST SHALL block the transfer, hold counter, owner and state; no data dropped or duplicated.
REQ-023 last[owner] with we=0 SHALL be ignored.
REQ-024 Changes of non-owner req bits during BURST SHALL not affect the current burst.
REQ-025 ack and we SHALL be 0 whenever gnt is all-zero.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, gnt=0, ptr=0, counter=0; hence ack=0, we=0, busy=0.
REQ-027 dout SHALL be din[0] while idle or in reset.
REQ-028 Reset asserted mid-burst SHALL abort it; first grant after release SHALL start search at index 0.

Configuration
REQ-029 Macro LDL_FIFO_WARB_PRIO_EN: when defined, selection SHALL be fixed priority (lowest index wins, ptr unused); when undefined, round-robin per REQ-017.
REQ-030 Burst termination, full handling and reset behaviour SHALL be identical in both builds.

Verification
REQ-031 N=4, req=4'b1111 held, last on every beat, full=0 -> gnt sequence 0,1,2,3,0, each one beat, busy low one cycle between.
REQ-032 req[2] only, last never asserted, MAXB=16 -> exactly 16 ack pulses, then IDLE, then new burst to requester 2.
REQ-033 Owner 1 mid-burst, full=1 for 3 cycles -> we=0, ack=0, counter held, resumes with next din[1] word unchanged.
REQ-034 Owner 3 at beat 5, rst pulsed low -> ack/we/gnt 0 immediately; req=4'b1010 after release grants requester 1 first.
REQ-035 LDL_FIFO_WARB_PRIO_EN defined, req=4'b1100 held, last on every beat -> requester 2 granted every burst, requester 3 never.
REQ-036 Owner 0 drops req after 2 beats, last never seen -> IDLE next cycle, ptr=1.
